// File: rtl/vga_timing_pipe.sv
`default_nettype none
// vga_timing_pipe: DEPTH-stage register pipe for VGA timing and pixel-coordinate bundles,
// with fill tracking, DE gating until primed, and a one-cycle frame-start pulse. Rev 1.0
module vga_timing_pipe #(
  parameter int DEPTH    = 3,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter bit SYNC_ACT = 1'b0
) (
  input  logic           pclk,
  input  logic           reset_n,
  input  logic           en,
  input  logic           flush,
  input  logic           DE_i,
  input  logic           h_sync_i,
  input  logic           v_sync_i,
  input  logic [X_W-1:0] x_pixel_i,
  input  logic [Y_W-1:0] y_pixel_i,
  output logic           DE_o,
  output logic           h_sync_o,
  output logic           v_sync_o,
  output logic [X_W-1:0] x_pixel_o,
  output logic [Y_W-1:0] y_pixel_o,
  output logic           primed_o,
  output logic           frame_start_o
);

  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic             SYNC_IDLE = ~SYNC_ACT;

  typedef struct packed {
    logic           de;
    logic           hs;
    logic           vs;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } bundle_t;

  localparam bundle_t IDLE = '{de: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE, x: '0, y: '0};

  bundle_t          stage_in;
  bundle_t          stage_q [DEPTH];
  bundle_t          last_prev;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_nxt;
  logic             primed_nxt;
  logic             vs_edge;
  logic             frame_start_q;

  assign stage_in = '{de: DE_i, hs: h_sync_i, vs: v_sync_i, x: x_pixel_i, y: y_pixel_i};

  // last_prev is what the output stage will load on the next enabled advance
  generate
    if (DEPTH == 1) begin : g_single
      assign last_prev = stage_in;
    end else begin : g_multi
      assign last_prev = stage_q[DEPTH-2];
    end
  endgenerate

  always_ff @(posedge pclk) begin
    if (!reset_n || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= IDLE;
      end
    end else if (en) begin
      stage_q[0] <= stage_in;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  always_comb begin
    fill_nxt   = (fill_q == CNT_MAX) ? fill_q : fill_q + CNT_W'(1);
    primed_nxt = primed_o | (fill_nxt == CNT_MAX);
    vs_edge    = (stage_q[DEPTH-1].vs == SYNC_IDLE) && (last_prev.vs == SYNC_ACT);
  end

  // the pulse is qualified by the post-edge primed state so the priming edge itself can fire
  always_ff @(posedge pclk) begin
    if (!reset_n || flush) begin
      fill_q        <= '0;
      primed_o      <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (en) begin
      fill_q        <= fill_nxt;
      primed_o      <= primed_nxt;
      frame_start_q <= vs_edge & primed_nxt;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign DE_o          = stage_q[DEPTH-1].de & primed_o;
  assign h_sync_o      = stage_q[DEPTH-1].hs;
  assign v_sync_o      = stage_q[DEPTH-1].vs;
  assign x_pixel_o     = stage_q[DEPTH-1].x;
  assign y_pixel_o     = stage_q[DEPTH-1].y;
  assign frame_start_o = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_pipe.sv
`default_nettype none
// tb_vga_timing_pipe: directed table plus randomized run against a history-queue model,
// covering DEPTH=3 (10-bit) and DEPTH=1/8 (11-bit) instances on shared stimulus. Rev 1.0
module tb_vga_timing_pipe;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, flush = 1'b0;
  logic        de_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [10:0] x_in = '0, y_in = '0;

  logic       de3, hs3, vs3, pr3, fs3;
  logic [9:0] x3, y3;
  logic        de1, hs1, vs1, pr1, fs1;
  logic [10:0] x1, y1;
  logic        de8, hs8, vs8, pr8, fs8;
  logic [10:0] x8, y8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 pclk = ~pclk;

  vga_timing_pipe #(.DEPTH(3), .X_W(10), .Y_W(10), .SYNC_ACT(1'b0)) u_dut3 (
    .pclk(pclk), .reset_n(rst_n), .en(en), .flush(flush),
    .DE_i(de_in), .h_sync_i(hs_in), .v_sync_i(vs_in),
    .x_pixel_i(x_in[9:0]), .y_pixel_i(y_in[9:0]),
    .DE_o(de3), .h_sync_o(hs3), .v_sync_o(vs3), .x_pixel_o(x3), .y_pixel_o(y3),
    .primed_o(pr3), .frame_start_o(fs3));

  vga_timing_pipe #(.DEPTH(1), .X_W(11), .Y_W(11), .SYNC_ACT(1'b0)) u_dut1 (
    .pclk(pclk), .reset_n(rst_n), .en(en), .flush(flush),
    .DE_i(de_in), .h_sync_i(hs_in), .v_sync_i(vs_in),
    .x_pixel_i(x_in), .y_pixel_i(y_in),
    .DE_o(de1), .h_sync_o(hs1), .v_sync_o(vs1), .x_pixel_o(x1), .y_pixel_o(y1),
    .primed_o(pr1), .frame_start_o(fs1));

  vga_timing_pipe #(.DEPTH(8), .X_W(11), .Y_W(11), .SYNC_ACT(1'b0)) u_dut8 (
    .pclk(pclk), .reset_n(rst_n), .en(en), .flush(flush),
    .DE_i(de_in), .h_sync_i(hs_in), .v_sync_i(vs_in),
    .x_pixel_i(x_in), .y_pixel_i(y_in),
    .DE_o(de8), .h_sync_o(hs8), .v_sync_o(vs8), .x_pixel_o(x8), .y_pixel_o(y8),
    .primed_o(pr8), .frame_start_o(fs8));

  // Reference model: output of a DEPTH-d pipe is the input accepted d advances ago,
  // or the idle bundle if fewer than d advances happened since the last clear.
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [10:0] x;
    logic [10:0] y;
  } bun_t;

  bun_t hist[$];
  int   n_adv = 0;
  logic exp_fs [3];
  int   depths [3] = '{3, 1, 8};

  function automatic bun_t exp_out(int d);
    bun_t b;
    b = '{de: 1'b0, hs: 1'b1, vs: 1'b1, x: 11'd0, y: 11'd0};
    if (n_adv >= d) b = hist[hist.size() - d];
    return b;
  endfunction

  task automatic model_update();
    logic pv [3];
    bun_t b;
    for (int i = 0; i < 3; i++) begin
      b = exp_out(depths[i]);
      pv[i] = b.vs;
    end
    if (!rst_n || flush) begin
      hist.delete();
      n_adv = 0;
      for (int i = 0; i < 3; i++) exp_fs[i] = 1'b0;
    end else if (en) begin
      hist.push_back('{de: de_in, hs: hs_in, vs: vs_in, x: x_in, y: y_in});
      if (hist.size() > 8) void'(hist.pop_front());
      if (n_adv < 1000) n_adv++;
      for (int i = 0; i < 3; i++) begin
        b = exp_out(depths[i]);
        exp_fs[i] = (pv[i] == 1'b1) && (b.vs == 1'b0) && (n_adv >= depths[i]);
      end
    end else begin
      for (int i = 0; i < 3; i++) exp_fs[i] = 1'b0;
    end
  endtask

  task automatic check_model();
    bun_t        b;
    logic        pr;
    logic [26:0] act, exp;
    for (int i = 0; i < 3; i++) begin
      b  = exp_out(depths[i]);
      pr = (n_adv >= depths[i]);
      if (i == 0) begin
        b.x[10] = 1'b0;
        b.y[10] = 1'b0;
      end
      exp = {b.de & pr, b.hs, b.vs, b.x, b.y, pr, exp_fs[i]};
      case (i)
        0:       act = {de3, hs3, vs3, 1'b0, x3, 1'b0, y3, pr3, fs3};
        1:       act = {de1, hs1, vs1, x1, y1, pr1, fs1};
        default: act = {de8, hs8, vs8, x8, y8, pr8, fs8};
      endcase
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_depth%0d cycle %0d: got {de,hs,vs,x,y,primed,fs}=%h expected %h",
                 depths[i], cyc, act, exp);
      end
    end
  endtask

  task automatic step(input logic r, input logic e, input logic f, input logic d,
                      input logic h, input logic v, input logic [10:0] xx, input logic [10:0] yy);
    @(negedge pclk);
    rst_n = r; en = e; flush = f; de_in = d; hs_in = h; vs_in = v; x_in = xx; y_in = yy;
    @(posedge pclk);
    model_update();
    #1;
    cyc++;
    check_model();
  endtask

  // Directed vectors for the DEPTH=3 instance (DE_i=1, h_sync_i=1, y_in=x_in+100)
  typedef struct {
    logic rn, en, fl, vs;
    int   x;
    int   ex, ey;
    logic ede, epr, efs, evs;
  } vec_t;

  vec_t tbl [30];

  initial begin
    logic v_r;
    logic [25:0] act_t, exp_t;

    // reset, then fill: x_pixel_o=0 and primed on the 3rd edge
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 3; i <= 8; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, i - 1, i - 3, i - 3 + 100, 1'b1, 1'b1, 1'b0, 1'b1};
    // stall 4 cycles with output frozen at 5, then resume to 6
    for (int i = 9; i <= 12; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 8, 5, 105, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 8, 6, 106, 1'b1, 1'b1, 1'b0, 1'b1};
    // v_sync 1,1,0,0,0 -> falls 3 edges later with a single pulse
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 9,  7,  107, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 10, 8,  108, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 11, 9,  109, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 12, 10, 110, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 13, 11, 111, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 14, 12, 112, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 15, 13, 113, 1'b1, 1'b1, 1'b0, 1'b0};
    // flush with en=1 during active video, then 3-edge refill
    tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b1, 16, 0,  0,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 17, 0,  0,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 1'b1, 18, 0,  0,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[24] = '{1'b1, 1'b1, 1'b0, 1'b1, 19, 17, 117, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[25] = '{1'b1, 1'b1, 1'b0, 1'b1, 20, 18, 118, 1'b1, 1'b1, 1'b0, 1'b1};
    // reset together with flush and en mid-stream
    tbl[26] = '{1'b0, 1'b1, 1'b1, 1'b1, 21, 0,  0,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[27] = '{1'b1, 1'b1, 1'b0, 1'b1, 22, 0,  0,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[28] = '{1'b1, 1'b1, 1'b0, 1'b1, 23, 0,  0,   1'b0, 1'b0, 1'b0, 1'b1};
    tbl[29] = '{1'b1, 1'b1, 1'b0, 1'b1, 24, 22, 122, 1'b1, 1'b1, 1'b0, 1'b1};

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].rn, tbl[i].en, tbl[i].fl, 1'b1, 1'b1, tbl[i].vs,
           11'(tbl[i].x), 11'(tbl[i].x + 100));
      exp_t = {10'(tbl[i].ex), 10'(tbl[i].ey), tbl[i].ede, tbl[i].epr, tbl[i].efs,
               tbl[i].evs, 1'b1, 1'b0};
      act_t = {x3, y3, de3, pr3, fs3, vs3, hs3, 1'b0};
      checks++;
      if (act_t !== exp_t) begin
        errors++;
        $display("FAIL table_row%0d: got {x,y,de,primed,fs,vs,hs}=%h expected %h",
                 i, act_t, exp_t);
      end
    end

    // randomized traffic with occasional reset, flush and stalls; v_sync in runs
    v_r = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(7) == 0) v_r = ~v_r;
      step($urandom_range(49) != 0, $urandom_range(3) != 0, $urandom_range(24) == 0,
           1'($urandom_range(1)), 1'($urandom_range(1)), v_r,
           11'($urandom), 11'($urandom));
    end

    // long uninterrupted run: counters must saturate without wrapping
    for (int c = 0; c < 320; c++) begin
      if ($urandom_range(15) == 0) v_r = ~v_r;
      step(1'b1, 1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), v_r,
           11'($urandom), 11'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
